config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Transmitter end of the serial configuration chain protocol (config_in / config_clk / config_en / config_out) used by switch_box and the other configurable fabric tiles.
- Accepts the bitstream as parallel words over a valid/ready handshake and serializes it LSB-first onto the chain.
- Generates config_clk from the system clock.
- Sits between the host/bitstream memory and the head of the fabric's daisy-chained configuration shift registers.

Parameters:
- WORD_WIDTH, 32, width of each incoming bitstream word.
- CHAIN_LENGTH, 32, total chain bits to shift per load (32 = one switch_box with WIDTH=2); must be >= 1.
- CLK_DIV, 2, system clk cycles per config_clk half-period; must be >= 1.

Ports:
- clk  input  1  system clock; every internal register is clocked on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; ignored while busy=1.
- word_data  input  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader can accept a word.
- config_in  output  1  serial data to the chain head.
- config_clk  output  1  generated shift clock; the chain shifts on its rising edge.
- config_en  output  1  chain shift enable.
- config_out  input  1  serial data returning from the chain tail.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the load completes.
- tx_crc  output  16  CRC of transmitted bits (optional feature; 0 when the feature is compiled out).
- rx_crc  output  16  CRC of bits returned on config_out (optional feature; 0 when the feature is compiled out).

Behaviour:
- Reset values: all outputs 0, state IDLE, bit counter 0.
  - Async reset mid-load aborts immediately.
  - Chain contents are left partial; no recovery is attempted.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE -> FETCH on start. busy=1 from the next cycle. bit_cnt=0.
- FETCH:
  - word_ready=1.
  - On word_valid & word_ready: latch the word into the shift register; word_ready drops the next cycle; go to SHIFT_LO.
  - Starvation (word_valid=0): wait indefinitely. config_clk stays 0, config_en stays as is.
- SHIFT_LO:
  - config_en=1, config_clk=0, config_in=shreg[0].
  - Held for CLK_DIV cycles, then go to SHIFT_HI.
  - config_out is sampled on the last SHIFT_LO cycle, before the rising edge.
- SHIFT_HI:
  - config_clk=1 for CLK_DIV cycles; config_in is held stable.
  - On exit: shreg >>= 1, bit_cnt++.
- SHIFT_HI exit transitions:
  - If bit_cnt == CHAIN_LENGTH: go to FINISH.
  - Else if the current word is exhausted (WORD_WIDTH bits sent): go to FETCH.
  - Else: go to SHIFT_LO.
- Per-bit period: exactly 2*CLK_DIV clk cycles, excluding FETCH stalls.
- FETCH between words:
  - Adds at least 1 cycle with config_clk=0 and config_en=1.
  - The chain does not shift during this time.
- Partial last word: ceil(CHAIN_LENGTH/WORD_WIDTH) words are consumed in total. Unused upper bits of the last word are discarded. No extra words are requested.
- FINISH (1 cycle):
  - config_en=0, config_clk=0, config_in=0, done=1.
  - busy=0 from the next cycle; return to IDLE.
- Exactly CHAIN_LENGTH config_clk rising edges occur per load.
- start asserted in FINISH or while busy is ignored.
- start is sampled again in IDLE.

Optional Feature:
- Macro: CONFIG_LOADER_CRC_EN.
- With the macro defined:
  - tx_crc and rx_crc are serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first register, no reflection, no final XOR).
  - tx_crc is fed each bit as it is driven on config_in.
  - rx_crc is fed each config_out sample.
  - Both CRCs reset to 0xFFFF on start.
  - Both hold their values after done.
  - Loading the same stream twice makes rx_crc of the second load equal tx_crc of the first (readback verify).
- Without the macro: tx_crc and rx_crc are tied to 0 and no CRC logic is built.

Decomposition:
- Package config_loader_pkg:
  - State enum.
  - CRC16_POLY = 16'h1021.
  - CRC16_INIT = 16'hFFFF.
- Sub-module crc16_serial (clk, rst_n, clr, en, bit_in, crc). Instantiated twice under the macro.

Test Plan:
- Default parameters, start, word 32'h55555555 held valid:
  - 32 config_clk rising edges.
  - config_in at the edges = 1,0,1,0,...
  - Each bit high for 2 clk cycles and low for 2 clk cycles.
  - config_en low before the first bit and after the last bit.
  - done pulses once.
  - A switch_box model on the chain shows straight-through routing.
- CHAIN_LENGTH=40, words 32'hFFFFFFFF then 32'h000000A5:
  - Exactly 2 handshakes and 40 edges.
  - Last 8 bits = 1,0,1,0,0,1,0,1.
  - No third word_ready.
- word_valid withheld 10 cycles before the second word: config_clk held 0 and config_en held 1 throughout; no extra edges; total edges unchanged.
- rst_n pulled low after 10 edges:
  - All outputs 0 asynchronously.
  - After release, a new start loads cleanly.
- start pulsed while busy: ignored; edge count and done count unchanged.
- CONFIG_LOADER_CRC_EN, 32-bit loopback chain, 32'hFFFFFFFF loaded twice:
  - Second load rx_crc == first load tx_crc.
  - A flipped config_out bit breaks the match.

Source files
------------

// File: rtl/config_chain_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
// The CRC helper is only used when CONFIG_LOADER_CRC_EN is defined.
package config_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT_LO,
      SHIFT_HI,
      FINISH
   } load_state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // One serial step of CRC-16-CCITT, MSB-first, no reflection.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      return {crc[14:0], 1'b0} ^ (((crc[15] ^ bit_in) == 1'b1) ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Word handshake between the bitstream source (master) and the loader (slave).
interface config_chain_loader_if #(
   parameter int WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] word_data;
   logic                  word_valid;
   logic                  word_ready;

   modport master (output word_data, output word_valid, input word_ready);
   modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader_crc.sv
// Serial CRC-16-CCITT accumulator: clr reloads the init value, en folds in one bit.
module crc16_serial
   import config_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= 16'h0000;
      end else if (clr) begin
         crc <= CRC16_INIT;
      end else if (en) begin
         crc <= crc16_step(crc, bit_in);
      end
   end

endmodule

// File: rtl/config_chain_loader.sv
// Serializes bitstream words LSB-first onto the fabric configuration chain.
// Define CONFIG_LOADER_CRC_EN to build the tx/rx readback CRCs.
module config_chain_loader
   import config_loader_pkg::*;
#(
   parameter int WORD_WIDTH   = 32,
   parameter int CHAIN_LENGTH = 32,
   parameter int CLK_DIV      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   config_chain_loader_if.slave  word_bus,
   output logic                  config_in,
   output logic                  config_clk,
   output logic                  config_en,
   input  logic                  config_out,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           tx_crc,
   output logic [15:0]           rx_crc
);

   localparam int BIT_W  = $clog2(CHAIN_LENGTH + 1);
   localparam int WBIT_W = $clog2(WORD_WIDTH + 1);
   localparam int DIV_W  = $clog2(CLK_DIV + 1);

   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CHAIN_LENGTH - 1);
   localparam logic [WBIT_W-1:0] WORD_LAST = WBIT_W'(WORD_WIDTH - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

   load_state_t             state_reg, state_next;
   logic [BIT_W-1:0]        bit_cnt_reg;
   logic [WBIT_W-1:0]       word_bit_reg;
   logic [DIV_W-1:0]        div_cnt_reg;
   logic [WORD_WIDTH-1:0]   shreg_reg;

   logic begin_load;
   logic load_word;
   logic lo_tick;
   logic bit_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next          = state_reg;
      begin_load          = 1'b0;
      load_word           = 1'b0;
      lo_tick             = 1'b0;
      bit_tick            = 1'b0;
      word_bus.word_ready = 1'b0;
      config_in           = 1'b0;
      config_clk          = 1'b0;
      config_en           = 1'b0;
      busy                = 1'b1;
      done                = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               begin_load = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: begin
            word_bus.word_ready = 1'b1;
            // Enable is held only between words; the first fetch keeps the chain idle.
            config_en = (bit_cnt_reg != '0);
            if (word_bus.word_valid) begin
               load_word  = 1'b1;
               state_next = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            config_en = 1'b1;
            config_in = shreg_reg[0];
            if (div_cnt_reg == DIV_LAST) begin
               lo_tick    = 1'b1;
               state_next = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            config_en  = 1'b1;
            config_clk = 1'b1;
            config_in  = shreg_reg[0];
            if (div_cnt_reg == DIV_LAST) begin
               bit_tick = 1'b1;
               if (bit_cnt_reg == BIT_LAST) begin
                  state_next = FINISH;
               end else if (word_bit_reg == WORD_LAST) begin
                  state_next = FETCH;
               end else begin
                  state_next = SHIFT_LO;
               end
            end
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_reg  <= '0;
         word_bit_reg <= '0;
         div_cnt_reg  <= '0;
         shreg_reg    <= '0;
      end else begin
         if (begin_load) begin
            bit_cnt_reg <= '0;
         end
         if (load_word) begin
            shreg_reg    <= word_bus.word_data;
            word_bit_reg <= '0;
            div_cnt_reg  <= '0;
         end else if (state_reg == SHIFT_LO || state_reg == SHIFT_HI) begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
            if (bit_tick) begin
               shreg_reg    <= shreg_reg >> 1;
               bit_cnt_reg  <= bit_cnt_reg + 1'b1;
               word_bit_reg <= word_bit_reg + 1'b1;
            end
         end
      end
   end

`ifdef CONFIG_LOADER_CRC_EN
   // Both CRCs advance once per bit, on the last low cycle before the chain edge.
   crc16_serial u_tx_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (begin_load),
      .en     (lo_tick),
      .bit_in (config_in),
      .crc    (tx_crc)
   );

   crc16_serial u_rx_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (begin_load),
      .en     (lo_tick),
      .bit_in (config_out),
      .crc    (rx_crc)
   );
`else
   logic unused_crc;
   assign unused_crc = &{1'b0, config_out, lo_tick};
   assign tx_crc     = 16'h0000;
   assign rx_crc     = 16'h0000;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench: two loaders (32-bit and 40-bit chains) driven with random words and stalls,
// checked against a bit-stream model and shift-register chain models.
`timescale 1ns/1ps
module tb_config_chain_loader;

   localparam int WW    = 32;
   localparam int LEN_A = 32;
   localparam int LEN_B = 40;
   localparam int DIV_A = 2;
   localparam int DIV_B = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  start_v;
   logic [1:0]  cin, cclk, cen, cout, busy_v, done_v;
   logic [15:0] txc_a, rxc_a, txc_b, rxc_b;
   logic        flip_a;

   config_chain_loader_if #(.WORD_WIDTH(WW)) wif_a ();
   config_chain_loader_if #(.WORD_WIDTH(WW)) wif_b ();

   config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(LEN_A), .CLK_DIV(DIV_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .word_bus(wif_a),
      .config_in(cin[0]), .config_clk(cclk[0]), .config_en(cen[0]), .config_out(cout[0]),
      .busy(busy_v[0]), .done(done_v[0]), .tx_crc(txc_a), .rx_crc(rxc_a)
   );

   config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(LEN_B), .CLK_DIV(DIV_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .word_bus(wif_b),
      .config_in(cin[1]), .config_clk(cclk[1]), .config_en(cen[1]), .config_out(cout[1]),
      .busy(busy_v[1]), .done(done_v[1]), .tx_crc(txc_b), .rx_crc(rxc_b)
   );

   // Chain models: head shifts in on config_clk rise while enabled, tail loops back.
   logic [LEN_A-1:0] chain_a = '0;
   logic [LEN_B-1:0] chain_b = '0;
   always @(posedge cclk[0]) if (cen[0]) chain_a <= {chain_a[LEN_A-2:0], cin[0]};
   always @(posedge cclk[1]) if (cen[1]) chain_b <= {chain_b[LEN_B-2:0], cin[1]};
   assign cout[0] = chain_a[LEN_A-1] ^ flip_a;
   assign cout[1] = chain_b[LEN_B-1];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Monitor: cumulative counters, sampled on the falling edge.
   int   edges[2]     = '{0, 0};
   int   hs[2]        = '{0, 0};
   int   dones[2]     = '{0, 0};
   int   errs[2]      = '{0, 0};
   int   hi_run[2]    = '{0, 0};
   int   lo_run[2]    = '{0, 0};
   int   load_e0[2]   = '{0, 0};
   logic prev_clk[2]  = '{1'b0, 1'b0};
   logic last_bit[2]  = '{1'b0, 1'b0};
   bit   gbits[2][4096];

   function automatic logic rdy_of(input int s);
      return (s == 0) ? wif_a.word_ready : wif_b.word_ready;
   endfunction

   function automatic logic vld_of(input int s);
      return (s == 0) ? wif_a.word_valid : wif_b.word_valid;
   endfunction

   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         int div;
         div = (s == 0) ? DIV_A : DIV_B;
         if (!rst_n) begin
            prev_clk[s] = 1'b0;
            hi_run[s]   = 0;
            lo_run[s]   = 0;
         end else begin
            if (cclk[s] && !prev_clk[s]) begin
               gbits[s][edges[s] % 4096] = cin[s];
               edges[s]++;
               last_bit[s] = cin[s];
               if (!cen[s]) errs[s]++;
               if (lo_run[s] != div) errs[s]++;
               lo_run[s] = 0;
            end
            if (cclk[s]) begin
               hi_run[s]++;
               if (cin[s] != last_bit[s]) errs[s]++;
            end else begin
               if (prev_clk[s]) begin
                  if (hi_run[s] != div) errs[s]++;
                  hi_run[s] = 0;
               end
               if (cen[s] && !rdy_of(s)) lo_run[s]++;
            end
            // While a word is being fetched the clock idles low; enable is held only mid-load.
            if (rdy_of(s) && (cclk[s] || (cen[s] != (edges[s] != load_e0[s])))) errs[s]++;
            if (rdy_of(s) && vld_of(s)) hs[s]++;
            if (done_v[s]) dones[s]++;
            prev_clk[s] = cclk[s];
         end
      end
   end

   logic [WW-1:0] words  [0:3];
   int            stalls [0:3];

   task automatic drive_word(input int s, input logic [WW-1:0] d, input logic v);
      if (s == 0) begin
         wif_a.word_data = d; wif_a.word_valid = v;
      end else begin
         wif_b.word_data = d; wif_b.word_valid = v;
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [63:0] bits, input int n);
      logic [16:0] c;
      c = 17'h0FFFF;
      for (int k = 0; k < n; k++) begin
         c = c << 1;
         if (c[16] ^ bits[k]) c[15:0] = c[15:0] ^ 16'h1021;
         c[16] = 1'b0;
      end
      return c[15:0];
   endfunction

   logic [63:0] last_exp;

   task automatic do_load(input int s, input int len, input int poke);
      int nw, e0, h0, d0, r0;
      logic [63:0] exp_bits, got_bits, exp_chain, got_chain;
      nw = (len + WW - 1) / WW;
      e0 = edges[s]; h0 = hs[s]; d0 = dones[s]; r0 = errs[s];
      load_e0[s] = e0;
      @(posedge clk); #1; start_v[s] = 1'b1;
      @(posedge clk); #1; start_v[s] = 1'b0;
      check_eq("busy_after_start", busy_v[s], 1'b1);
      fork
         begin
            if (poke > 0) begin
               repeat (poke) @(posedge clk);
               #1; start_v[s] = 1'b1;
               @(posedge clk); #1; start_v[s] = 1'b0;
            end
         end
         begin
            logic got;
            for (int w = 0; w < nw; w++) begin
               drive_word(s, WW'($urandom), 1'b0);
               repeat (stalls[w]) begin @(posedge clk); #1; end
               drive_word(s, words[w], 1'b1);
               got = 1'b0;
               for (int c = 0; c < 5000 && !got; c++) begin
                  @(negedge clk); got = rdy_of(s);
               end
               if (!got) begin
                  check_eq("handshake_timeout", 0, 1);
                  break;
               end
               @(posedge clk); #1;
            end
            // Keep offering garbage: a surplus request would show up as an extra handshake.
            drive_word(s, WW'($urandom), 1'b1);
            got = 1'b0;
            for (int c = 0; c < 20000 && !got; c++) begin
               @(negedge clk); got = done_v[s];
            end
            if (!got) begin
               check_eq("done_timeout", 0, 1);
            end else begin
               check_eq("finish_outputs", {cin[s], cclk[s], cen[s], busy_v[s]}, 4'b0001);
               @(negedge clk);
               check_eq("idle_outputs", {busy_v[s], done_v[s], cen[s], cclk[s], rdy_of(s)}, 5'b0);
            end
            drive_word(s, '0, 1'b0);
         end
      join
      repeat (3) @(posedge clk);
      #1;
      exp_bits = '0; got_bits = '0; exp_chain = '0;
      for (int k = 0; k < len; k++) begin
         exp_bits[k]           = words[k / WW][k % WW];
         got_bits[k]           = gbits[s][(e0 + k) % 4096];
         exp_chain[len - 1 - k] = exp_bits[k];
      end
      got_chain = (s == 0) ? 64'(chain_a) : 64'(chain_b);
      last_exp  = exp_bits;
      check_eq("edge_count", edges[s] - e0, len);
      check_eq("bit_stream", got_bits, exp_bits);
      check_eq("handshakes", hs[s] - h0, nw);
      check_eq("done_pulses", dones[s] - d0, 1);
      check_eq("timing_errs", errs[s] - r0, 0);
      check_eq("chain_contents", got_chain, exp_chain);
      $display("[TB] load dut%0d len=%0d words=%0d stall1=%0d poke=%0d edges=%0d bits=%h",
               s, len, nw, stalls[1], poke, edges[s] - e0, got_bits);
   endtask

   initial begin
      int e0;
      logic [15:0] tx1;
      rst_n = 1'b0; start_v = '0; flip_a = 1'b0;
      drive_word(0, '0, 1'b0);
      drive_word(1, '0, 1'b0);
      for (int i = 0; i < 4; i++) stalls[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outputs_a", {cin[0], cclk[0], cen[0], busy_v[0], done_v[0], wif_a.word_ready}, 6'b0);
      check_eq("reset_outputs_b", {cin[1], cclk[1], cen[1], busy_v[1], done_v[1], wif_b.word_ready}, 6'b0);
      check_eq("reset_crc", {txc_a, rxc_a}, 32'h0);
      rst_n = 1'b1;

      words[0] = 32'h55555555;
      do_load(0, LEN_A, 0);

      words[0] = 32'hFFFFFFFF; words[1] = 32'h000000A5;
      do_load(1, LEN_B, 0);
      check_eq("last8_bits", last_exp[39:32], 8'hA5);
      stalls[1] = 10;
      do_load(1, LEN_B, 7);

      for (int i = 0; i < 4; i++) begin
         for (int w = 0; w < 4; w++) begin
            words[w]  = WW'($urandom);
            stalls[w] = $urandom_range(0, 4);
         end
         do_load(0, LEN_A, ($urandom_range(0, 1) == 1) ? $urandom_range(3, 40) : 0);
         do_load(1, LEN_B, ($urandom_range(0, 1) == 1) ? $urandom_range(3, 40) : 0);
      end

      // Asynchronous reset after 10 chain edges aborts the load.
      for (int w = 0; w < 4; w++) stalls[w] = 0;
      words[0] = WW'($urandom);
      e0 = edges[0];
      load_e0[0] = e0;
      drive_word(0, words[0], 1'b1);
      @(posedge clk); #1; start_v[0] = 1'b1;
      @(posedge clk); #1; start_v[0] = 1'b0;
      for (int c = 0; c < 2000 && (edges[0] - e0) < 10; c++) @(negedge clk);
      check_eq("edges_before_reset", edges[0] - e0, 10);
      #2; rst_n = 1'b0;
      #1;
      check_eq("async_reset_outputs",
               {cin[0], cclk[0], cen[0], busy_v[0], done_v[0], wif_a.word_ready}, 6'b0);
      drive_word(0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      words[0] = WW'($urandom);
      do_load(0, LEN_A, 0);

`ifdef CONFIG_LOADER_CRC_EN
      words[0] = 32'hFFFFFFFF;
      do_load(0, LEN_A, 0);
      tx1 = txc_a;
      check_eq("tx_crc_model", tx1, crc_model(64'h0FFFFFFFF, LEN_A));
      do_load(0, LEN_A, 0);
      check_eq("rx_readback", rxc_a, tx1);
      flip_a = 1'b1;
      do_load(0, LEN_A, 0);
      flip_a = 1'b0;
      check_eq("rx_flip_differs", (rxc_a != tx1), 1'b1);
`else
      tx1 = crc_model(64'h0, 0);
      check_eq("crc_tied_off", {txc_a, rxc_a, txc_b, rxc_b}, 64'h0);
      check_eq("crc_init_const", tx1, 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
